// File: rtl/lead_zero_scan.sv
// Performance-option type shared by the arithmetic library blocks.
package lau_pkg;
    typedef enum logic {FAST = 1'b0, SMALL = 1'b1} speed_e;
endpackage

// Per-chunk leading-one detector: count of zeros above the first '1', plus its one-hot position.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module lzs_chunk_det #(
    parameter int               chunk = 8,
    parameter lau_pkg::speed_e  speed = lau_pkg::FAST,
    parameter int               LW    = (chunk > 1) ? $clog2(chunk) : 1
) (
    input  logic [chunk-1:0] dat_i,
    output logic             nz_o,
    output logic [LW-1:0]    lz_o,
    output logic [chunk-1:0] oh_o
);

    assign nz_o = |dat_i;

    if (speed == lau_pkg::FAST) begin : g_fast
        logic seen;

        // One-hot first, then a flat OR-encode so the count does not sit behind a priority chain.
        always_comb begin
            oh_o = '0;
            lz_o = '0;
            seen = 1'b0;
            for (int i = chunk - 1; i >= 0; i--) begin
                oh_o[i] = dat_i[i] & ~seen;
                seen    = seen | dat_i[i];
            end
            for (int i = 0; i < chunk; i++) begin
                if (oh_o[i]) lz_o = lz_o | LW'(chunk - 1 - i);
            end
        end
    end else begin : g_small
        always_comb begin
            lz_o = '0;
            oh_o = '0;
            for (int i = 0; i < chunk; i++) begin
                if (dat_i[i]) lz_o = LW'(chunk - 1 - i);
            end
            for (int i = 0; i < chunk; i++) begin
                oh_o[i] = nz_o && (lz_o == LW'(chunk - 1 - i));
            end
        end
    end

endmodule

// Sequential leading/trailing zero/one counter, one chunk examined per cycle from the search end.
// Latency: 1 to width/chunk cycles from accept to out_valid_o, early exit on the first hit chunk.
// Backpressure: result held in DONE until out_ready_i; in_ready_o only in IDLE, no overlap.
module lead_zero_scan #(
    parameter int              width = 32,
    parameter int              chunk = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [width-1:0]             A_i,
    input  logic [1:0]                   mode_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [$clog2(width+1)-1:0]   cnt_o,
    output logic [width-1:0]             Z_o,
    output logic                         zero_o
);

    localparam int NCH = width / chunk;
    localparam int CW  = $clog2(width + 1);
    localparam int JW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW  = (chunk > 1) ? $clog2(chunk) : 1;

    if (width < 2 || chunk < 1 || (width % chunk) != 0) begin : g_param_check
        $error("lead_zero_scan: width must be >= 2 and chunk must divide width");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e           state_q, state_d;
    logic [width-1:0] n_q, n_d;
    logic             rev_q, rev_d;
    logic [JW-1:0]    j_q, j_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] z_q, z_d;
    logic             zero_q, zero_d;

    logic [width-1:0] a_inv, a_rev, a_norm;
    logic [chunk-1:0] slice [NCH];
    logic [chunk-1:0] cur_chunk;
    logic             det_nz;
    logic [LW-1:0]    det_lz;
    logic [chunk-1:0] det_oh;
    logic [width-1:0] z_norm, z_rev, z_hit;
    logic [CW-1:0]    cnt_hit;
    logic             last_chunk;

    // Every mode is reduced to "leading zeros of N" so one detector serves all four.
    always_comb begin
        a_inv = mode_i[0] ? ~A_i : A_i;
        a_rev = '0;
        for (int i = 0; i < width; i++) begin
            a_rev[i] = a_inv[width-1-i];
        end
        a_norm = mode_i[1] ? a_rev : a_inv;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slice
        assign slice[k] = n_q[width-1-k*chunk -: chunk];
        // Placing the chunk one-hot by slot keeps width out of the Z path (no wide shifter).
        assign z_norm[width-1-k*chunk -: chunk] = (j_q == JW'(k)) ? det_oh : '0;
    end

    assign cur_chunk = slice[j_q];

    lzs_chunk_det #(
        .chunk (chunk),
        .speed (speed)
    ) u_det (
        .dat_i (cur_chunk),
        .nz_o  (det_nz),
        .lz_o  (det_lz),
        .oh_o  (det_oh)
    );

    always_comb begin
        z_rev = '0;
        for (int i = 0; i < width; i++) begin
            z_rev[i] = z_norm[width-1-i];
        end
        z_hit = rev_q ? z_rev : z_norm;
    end

    assign cnt_hit    = CW'(j_q) * CW'(chunk) + CW'(det_lz);
    assign last_chunk = (j_q == JW'(NCH - 1));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        rev_d   = rev_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        zero_d  = zero_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        n_d     = a_norm;
                        rev_d   = mode_i[1];
                        j_d     = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (det_nz) begin
                        cnt_d   = cnt_hit;
                        z_d     = z_hit;
                        zero_d  = 1'b0;
                        state_d = DONE;
                    end else if (last_chunk) begin
                        cnt_d   = CW'(width);
                        z_d     = '0;
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            n_q     <= '0;
            rev_q   <= 1'b0;
            j_q     <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rev_q   <= rev_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign cnt_o       = cnt_q;
    assign Z_o         = z_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_lead_zero_scan.sv
// Scoreboard bench for lead_zero_scan (width 32, chunk 8) with directed, hand-computed vectors.
// Driver pushes expectations; a negedge monitor pops and checks result, latency and hold.
module tb_lead_zero_scan;

    logic        clk = 1'b0;
    logic        rst_ni, clear_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, zero_o;
    logic [31:0] A_i, Z_o;
    logic [1:0]  mode_i;
    logic [5:0]  cnt_o;

    always #5 clk = ~clk;

    lead_zero_scan #(.width(32), .chunk(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .A_i         (A_i),
        .mode_i      (mode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .cnt_o       (cnt_o),
        .Z_o         (Z_o),
        .zero_o      (zero_o)
    );

    typedef struct {
        logic [5:0]  cnt;
        logic [31:0] z;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_issued = 0;
    int   mlat;
    logic prev_v = 1'b0;
    bit   took;

    localparam int NV = 12;
    logic [1:0]  vm [NV] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd3, 2'd0, 2'd2, 2'd1};
    logic [31:0] va [NV] = '{32'h0000_0500, 32'h0000_0000, 32'h0000_0000, 32'hFFF0_0000,
                             32'h8000_0000, 32'h0000_00FF, 32'h0000_0001, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'h0000_0001, 32'h0001_0000, 32'hFFFF_FFFE};
    logic [5:0]  vc [NV] = '{6'd21, 6'd32, 6'd0, 6'd12, 6'd31, 6'd8, 6'd0, 6'd0, 6'd32, 6'd31, 6'd16, 6'd31};
    logic [31:0] vz [NV] = '{32'h0000_0400, 32'h0000_0000, 32'h8000_0000, 32'h0008_0000,
                             32'h8000_0000, 32'h0000_0100, 32'h0000_0001, 32'h8000_0000,
                             32'h0000_0000, 32'h0000_0001, 32'h0001_0000, 32'h0000_0001};
    logic        vzr [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int          vl [NV] = '{3, 4, 1, 2, 4, 2, 1, 1, 4, 4, 3, 4};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (!rst_ni) begin
            acc_q.delete();
            prev_v = 1'b0;
        end else begin
            if (clear_i) begin
                acc_q.delete();
            end else if (in_valid_i && in_ready_o) begin
                acc_q.push_back(cyc + 1);
                n_acc++;
            end
            if (out_valid_o && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    cur  = exp_q.pop_front();
                    mlat = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
                    chk("cnt", 64'(cnt_o), 64'(cur.cnt));
                    chk("Z", 64'(Z_o), 64'(cur.z));
                    chk("zero", 64'(zero_o), 64'(cur.zero));
                    chk("latency", 64'(mlat), 64'(cur.lat));
                end
            end else if (out_valid_o) begin
                chk("hold", 64'({cnt_o, Z_o, zero_o}), 64'({cur.cnt, cur.z, cur.zero}));
            end
            prev_v = out_valid_o;
        end
    end

    task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [5:0] c,
                        input logic [31:0] z, input logic zr, input int lat,
                        input bit push, input bit wait_done);
        exp_t e;
        bit   ok;
        @(posedge clk);
        #1;
        mode_i     = m;
        A_i        = a;
        in_valid_i = 1'b1;
        n_issued++;
        if (push) begin
            e.cnt  = c;
            e.z    = z;
            e.zero = zr;
            e.lat  = lat;
            exp_q.push_back(e);
        end
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready_o;
            @(posedge clk);
            #1;
        end
        in_valid_i = 1'b0;
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        if (wait_done) begin
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk);
                ok = in_ready_o;
            end
            if (!ok) chk("done_timeout", 64'd0, 64'd1);
        end
    endtask

    initial begin
        exp_t e;
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        A_i         = '0;
        mode_i      = '0;
        out_ready_i = 1'b1;
        #12;
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_outputs", 64'({cnt_o, Z_o, zero_o}), 64'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) begin
            send(vm[i], va[i], vc[i], vz[i], vzr[i], vl[i], 1'b1, 1'b1);
        end

        // Backpressure: result must hold while the input side is hammered.
        out_ready_i = 1'b0;
        send(2'd0, 32'h00F0_0000, 6'd8, 32'h0080_0000, 1'b0, 2, 1'b1, 1'b0);
        took = 1'b0;
        for (int k = 0; k < 20 && !took; k++) begin
            @(negedge clk);
            took = out_valid_o;
        end
        if (!took) chk("bp_valid_timeout", 64'd0, 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid_i = ~in_valid_i;
            A_i        = A_i ^ 32'hA5A5_0F0F;
            mode_i     = mode_i + 2'd1;
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready_o), 64'd0);
            chk("bp_out_valid", 64'(out_valid_o), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_idle", 64'(in_ready_o), 64'd1);
        send(2'd1, 32'h1234_5678, 6'd0, 32'h8000_0000, 1'b0, 1, 1'b1, 1'b1);

        // Clear mid-scan with a competing operand: aborted op yields nothing, new op waits a cycle.
        send(2'd0, 32'h0000_0001, 6'd31, 32'h0000_0001, 1'b0, 4, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        clear_i    = 1'b1;
        in_valid_i = 1'b1;
        mode_i     = 2'd2;
        A_i        = 32'h0000_0008;
        n_issued++;
        e.cnt  = 6'd3;
        e.z    = 32'h0000_0008;
        e.zero = 1'b0;
        e.lat  = 1;
        exp_q.push_back(e);
        @(negedge clk);
        chk("clear_scan_ready", 64'(in_ready_o), 64'd0);
        @(posedge clk);
        #1 clear_i = 1'b0;
        @(negedge clk);
        chk("clear_to_idle", 64'(in_ready_o), 64'd1);
        chk("clear_no_valid", 64'(out_valid_o), 64'd0);
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        took = 1'b0;
        for (int k = 0; k < 20 && !took; k++) begin
            @(negedge clk);
            took = in_ready_o;
        end
        if (!took) chk("clear_done_timeout", 64'd0, 64'd1);

        // Asynchronous reset in the middle of a scan.
        send(2'd0, 32'h0000_0001, 6'd31, 32'h0000_0001, 1'b0, 4, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_ni = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready_o), 64'd1);
        chk("arst_out_valid", 64'(out_valid_o), 64'd0);
        chk("arst_cnt", 64'(cnt_o), 64'd0);
        chk("arst_Z", 64'(Z_o), 64'd0);
        chk("arst_zero", 64'(zero_o), 64'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        send(2'd0, 32'h0000_3000, 6'd18, 32'h0000_2000, 1'b0, 3, 1'b1, 1'b1);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("accept_count", 64'(n_acc), 64'(n_issued));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
